channel_arbiter: RTL and testbench

Packet-level round-robin arbiter sharing one YAPP output channel (data_vld / suspend / data[7:0]) among NUM_REQ byte-stream requesters. Grants one requester per packet, forwards the whole packet (header, payload, parity) without interleaving, and honours channel back-pressure via suspend. Sits between the router's per-source packet buffers and a single channel output port.

---
 rtl/channel_arbiter.sv | 136 +++++++++++++
 tb/tb_channel_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_arbiter.sv
// Packet-level round-robin arbiter: grants one byte-stream requester per YAPP
// packet and forwards header, payload and parity onto a single channel.
module channel_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_vld_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ack_o,
  input  logic                 suspend_i,
  output logic                 data_vld_o,
  output logic [7:0]           data_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 busy_o,
  output logic                 pkt_done_o
);

  typedef enum logic {ST_IDLE, ST_XFER} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [6:0]       remaining_q, remaining_d;
  logic             first_byte_q, first_byte_d;
  logic [7:0]       data_q, data_d;
  logic             data_vld_q, data_vld_d;
  logic             pkt_done_q, pkt_done_d;

  logic [7:0]       req_bytes [NUM_REQ];
  logic [7:0]       owner_byte;
  logic             owner_vld;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand_int;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data_i[8*g +: 8];
  end

  assign owner_byte = req_bytes[grant_q];
  assign owner_vld  = req_vld_i[grant_q];

  // Search upward from the requester after the last owner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_int   = 0;
    cand_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_int = int'(last_grant_q) + off;
      if (cand_int >= NUM_REQ) cand_int = cand_int - NUM_REQ;
      cand_idx = IDX_W'(cand_int);
      if (!pick_found && req_vld_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    remaining_d  = remaining_q;
    first_byte_d = first_byte_q;
    data_d       = data_q;
    data_vld_d   = 1'b0;
    pkt_done_d   = 1'b0;
    req_ack_o    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!suspend_i && pick_found) begin
          state_d      = ST_XFER;
          grant_d      = pick_idx;
          first_byte_d = 1'b1;
        end
      end
      ST_XFER: begin
        if (owner_vld && !suspend_i) begin
          req_ack_o[grant_q] = 1'b1;
          data_d             = owner_byte;
          data_vld_d         = 1'b1;
          if (first_byte_q) begin
            // Header: payload length plus the trailing parity byte.
            remaining_d  = {1'b0, owner_byte[7:2]} + 7'd1;
            first_byte_d = 1'b0;
          end else begin
            remaining_d = remaining_q - 7'd1;
            if (remaining_q == 7'd1) begin
              state_d      = ST_IDLE;
              last_grant_d = grant_q;
              pkt_done_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      remaining_q  <= '0;
      first_byte_q <= 1'b0;
      data_q       <= 8'h00;
      data_vld_q   <= 1'b0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      remaining_q  <= remaining_d;
      first_byte_q <= first_byte_d;
      data_q       <= data_d;
      data_vld_q   <= data_vld_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  assign data_vld_o  = data_vld_q;
  assign data_o      = data_q;
  assign grant_idx_o = grant_q;
  assign busy_o      = (state_q == ST_XFER);
  assign pkt_done_o  = pkt_done_q;

endmodule

// File: tb/tb_channel_arbiter.sv
// Scoreboard bench for channel_arbiter: requester byte queues feed the DUT,
// expected channel bytes are queued when packets are loaded.
module tb_channel_arbiter;

  localparam int NUM_REQ = 3;
  localparam int IDX_W   = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_vld;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 suspend;
  logic                 data_vld;
  logic [7:0]           data;
  logic [IDX_W-1:0]     grant_idx;
  logic                 busy;
  logic                 pkt_done;

  channel_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vld_i  (req_vld),
    .req_data_i (req_data),
    .req_ack_o  (req_ack),
    .suspend_i  (suspend),
    .data_vld_o (data_vld),
    .data_o     (data),
    .grant_idx_o(grant_idx),
    .busy_o     (busy),
    .pkt_done_o (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]         src_q [NUM_REQ][$];
  exp_t               exp_q [$];
  int                 vld_log [$];
  int                 done_log [$];
  int                 grant_log [$];
  logic [NUM_REQ-1:0] ack_seen;
  logic               prev_busy;
  int                 cur_step;
  int                 n_checks;
  int                 n_fail;
  int                 susp_lo, susp_hi;
  int                 hold_lo, hold_hi, hold_who;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (step %0d)", tag, got, exp, cur_step);
    end
  endtask

  task automatic add_pkt(input int r, input logic [7:0] hdr, input logic [7:0] seed);
    logic [7:0] par;
    logic [7:0] b;
    par = hdr;
    src_q[r].push_back(hdr);
    exp_q.push_back('{data: hdr, last: 1'b0});
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b   = seed + 8'(i);
      par = par ^ b;
      src_q[r].push_back(b);
      exp_q.push_back('{data: b, last: 1'b0});
    end
    src_q[r].push_back(par);
    exp_q.push_back('{data: par, last: 1'b1});
  endtask

  task automatic drive();
    logic h;
    for (int i = 0; i < NUM_REQ; i++) begin
      h = (i == hold_who) && (cur_step + 1 >= hold_lo) && (cur_step + 1 <= hold_hi);
      req_vld[i] = (src_q[i].size() != 0) && !h;
      req_data[8*i +: 8] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
    end
    suspend = (cur_step + 1 >= susp_lo) && (cur_step + 1 <= susp_hi);
  endtask

  task automatic monitor();
    exp_t e;
    if (data_vld) begin
      vld_log.push_back(cur_step);
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {24'h0, data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("data", {24'h0, data}, {24'h0, e.data});
        check("pkt_done_with_byte", {31'h0, pkt_done}, {31'h0, e.last});
        if (e.last) check("busy_at_done", {31'h0, busy}, 32'd0);
      end
    end else begin
      check("pkt_done_no_byte", {31'h0, pkt_done}, 32'd0);
    end
    if (pkt_done) done_log.push_back(cur_step);
    if (busy && !prev_busy) grant_log.push_back(int'(grant_idx));
    prev_busy = busy;
    if (suspend) check("ack_during_suspend", {29'h0, req_ack}, 32'd0);
    if (cur_step >= hold_lo && cur_step <= hold_hi) begin
      check("ack_while_owner_idle", {29'h0, req_ack}, 32'd0);
      check("grant_held", {30'h0, grant_idx}, hold_who);
      check("busy_held", {31'h0, busy}, 32'd1);
    end
    ack_seen = req_ack;
  endtask

  task automatic step();
    @(negedge clk);
    cur_step++;
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (ack_seen[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + exp_q.size()) != 0 || busy) begin
      step();
      n++;
      if (n > budget) begin
        check("timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic clear_logs();
    vld_log.delete();
    done_log.delete();
    grant_log.delete();
    susp_lo = -10; susp_hi = -20;
    hold_lo = -10; hold_hi = -20; hold_who = 0;
  endtask

  initial begin
    int s;
    n_checks = 0; n_fail = 0; cur_step = 0;
    prev_busy = 1'b0; ack_seen = '0;
    rst_n = 1'b0; req_vld = '0; req_data = '0; suspend = 1'b0;
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_vld", {31'h0, data_vld}, 32'd0);
    check("rst_data", {24'h0, data}, 32'd0);
    check("rst_grant", {30'h0, grant_idx}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_pkt_done", {31'h0, pkt_done}, 32'd0);
    check("rst_req_ack", {29'h0, req_ack}, 32'd0);
    rst_n = 1'b1;

    // Three requesters with len-1 packets: round-robin 0,1,2,0 with one bubble each.
    clear_logs();
    add_pkt(0, 8'h04, 8'hA0);
    add_pkt(1, 8'h05, 8'hB0);
    add_pkt(2, 8'h06, 8'hC0);
    add_pkt(0, 8'h07, 8'hD0);
    drive();
    run_idle(200);
    check("rr_grants", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check("rr_g0", grant_log[0], 0);
      check("rr_g1", grant_log[1], 1);
      check("rr_g2", grant_log[2], 2);
      check("rr_g3", grant_log[3], 0);
    end
    check("rr_bytes", vld_log.size(), 12);
    if (vld_log.size() == 12)
      for (int i = 0; i < 11; i++)
        check("rr_spacing", vld_log[i+1] - vld_log[i], (i % 3 == 2) ? 2 : 1);

    // Single requester, header 0D: five consecutive bytes two cycles after request.
    clear_logs();
    add_pkt(0, 8'h0D, 8'h11);
    drive();
    s = cur_step;
    run_idle(100);
    check("single_bytes", vld_log.size(), 5);
    if (vld_log.size() == 5) begin
      check("single_first", vld_log[0], s + 3);
      check("single_last", vld_log[4], s + 7);
    end
    check("single_done_cnt", done_log.size(), 1);
    if (done_log.size() == 1) check("single_done_at", done_log[0], s + 7);
    check("single_busy_after", {31'h0, busy}, 32'd0);

    // Suspend for three cycles in the middle of a len-4 payload.
    clear_logs();
    add_pkt(1, 8'h12, 8'h40);
    drive();
    s = cur_step;
    susp_lo = s + 5; susp_hi = s + 7;
    run_idle(100);
    check("susp_bytes", vld_log.size(), 6);
    if (vld_log.size() == 6) begin
      check("susp_v2", vld_log[2], s + 5);
      check("susp_v3", vld_log[3], s + 9);
      check("susp_v5", vld_log[5], s + 11);
    end

    // Owner drops req_vld for two cycles while requester 2 is waiting.
    clear_logs();
    add_pkt(0, 8'h0E, 8'h60);
    drive();
    s = cur_step;
    hold_lo = s + 4; hold_hi = s + 5; hold_who = 0;
    repeat (3) step();
    add_pkt(2, 8'h05, 8'h70);
    drive();
    run_idle(100);
    check("hold_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("hold_g0", grant_log[0], 0);
      check("hold_g1", grant_log[1], 2);
    end
    check("hold_bytes", vld_log.size(), 8);
    if (vld_log.size() == 8) begin
      check("hold_resume", vld_log[2], s + 7);
      check("hold_parity", vld_log[4], s + 9);
    end

    // Length 0 then length 63 from the same requester.
    clear_logs();
    add_pkt(1, 8'h00, 8'h00);
    add_pkt(1, 8'hFC, 8'h80);
    drive();
    run_idle(300);
    check("len_bytes", vld_log.size(), 67);
    check("len_done_cnt", done_log.size(), 2);
    if (vld_log.size() == 67 && done_log.size() == 2) begin
      check("len0_done", done_log[0], vld_log[1]);
      check("len0_bubble", vld_log[2] - vld_log[1], 2);
      check("len63_done", done_log[1], vld_log[66]);
      check("len63_contig", vld_log[66] - vld_log[2], 64);
    end

    // Asynchronous reset two bytes into a len-5 packet.
    clear_logs();
    add_pkt(1, 8'h15, 8'h90);
    drive();
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("arst_data_vld", {31'h0, data_vld}, 32'd0);
    check("arst_busy", {31'h0, busy}, 32'd0);
    check("arst_req_ack", {29'h0, req_ack}, 32'd0);
    check("arst_grant", {30'h0, grant_idx}, 32'd0);
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
    drive();
    repeat (2) step();
    rst_n = 1'b1;
    clear_logs();
    add_pkt(0, 8'h09, 8'h20);
    add_pkt(1, 8'h08, 8'h30);
    drive();
    s = cur_step;
    run_idle(100);
    check("post_rst_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("post_rst_g0", grant_log[0], 0);
      check("post_rst_g1", grant_log[1], 1);
    end
    check("post_rst_bytes", vld_log.size(), 8);
    if (vld_log.size() == 8) check("post_rst_first", vld_log[0], s + 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
